// File: rtl/obstacle_sprite_loader_if.sv
// Command channel into the obstacle sprite loader: valid/ready handshake carrying
// either a 16-pixel load word or a per-sprite clear request.
interface obstacle_sprite_loader_if #(
    parameter int unsigned ADDR = 10
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_clear;
    logic [ADDR-5:0]   cmd_word;
    logic [31:0]       cmd_data;

    modport master (
        output cmd_valid,
        output cmd_clear,
        output cmd_word,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_clear,
        input  cmd_word,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/obstacle_sprite_loader.sv
// Write-side engine for the 2-bit palette sprite RAMs: turns one load (16 px) or
// clear (256 px) command into one-pixel-per-cycle RAM writes.
module obstacle_sprite_loader #(
    parameter int unsigned ADDR = 10
) (
    input  logic                   clk,
    input  logic                   reset_n,
    obstacle_sprite_loader_if.slave cmd,
    output logic                   we,
    output logic [ADDR-1:0]        addr_w,
    output logic [1:0]             pixel_out,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned WORD_W = ADDR - 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t              state_q;
    logic [7:0]          cnt_q;
    logic [WORD_W-1:0]   word_q;
    logic [31:0]         sh_q;

    logic                accept_c;
    logic [7:0]          cnt_nx_c;

    // Ready only in IDLE and never while reset is held.
    assign cmd.cmd_ready = (state_q == IDLE) && reset_n;
    assign accept_c      = cmd.cmd_valid && cmd.cmd_ready;
    assign cnt_nx_c      = 8'(cnt_q + 8'd1);

    // Write k is registered onto the RAM port while cnt_q == k; sh_q holds the pixels still pending.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            word_q    <= '0;
            sh_q      <= 32'd0;
            we        <= 1'b0;
            addr_w    <= '0;
            pixel_out <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    we   <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (accept_c) begin
                        cnt_q  <= 8'd0;
                        word_q <= cmd.cmd_word;
                        we     <= 1'b1;
                        busy   <= 1'b1;
                        if (cmd.cmd_clear) begin
                            state_q   <= CLEAR;
                            sh_q      <= cmd.cmd_data;
                            addr_w    <= {cmd.cmd_word[WORD_W-1:4], 8'd0};
                            pixel_out <= 2'b00;
                        end else begin
                            state_q   <= LOAD;
                            sh_q      <= {2'b00, cmd.cmd_data[31:2]};
                            addr_w    <= {cmd.cmd_word, 4'd0};
                            pixel_out <= cmd.cmd_data[1:0];
                        end
                    end
                end

                LOAD: begin
                    if (cnt_q == 8'd15) begin
                        state_q <= IDLE;
                        we      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_nx_c;
                        addr_w    <= {word_q, cnt_nx_c[3:0]};
                        pixel_out <= sh_q[1:0];
                        sh_q      <= {2'b00, sh_q[31:2]};
                    end
                end

                CLEAR: begin
                    if (cnt_q == 8'd255) begin
                        state_q <= IDLE;
                        we      <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        cnt_q     <= cnt_nx_c;
                        addr_w    <= {word_q[WORD_W-1:4], cnt_nx_c};
                        pixel_out <= 2'b00;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    we      <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obstacle_sprite_loader.sv
// Bench for obstacle_sprite_loader: directed and randomized commands checked
// against an arithmetic model of the expected RAM write stream.
module tb_obstacle_sprite_loader;

    localparam int unsigned ADDR = 10;

    logic            clk;
    logic            reset_n;
    logic            we;
    logic [ADDR-1:0] addr_w;
    logic [1:0]      pixel_out;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    obstacle_sprite_loader_if #(.ADDR(ADDR)) bus ();

    obstacle_sprite_loader #(.ADDR(ADDR)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd       (bus),
        .we        (we),
        .addr_w    (addr_w),
        .pixel_out (pixel_out),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: write k of a load lands at word*16+k with pixel k of data; a clear fills sid*256+k with 0.
    function automatic logic [11:0] model_write(input bit clr, input logic [5:0] word,
                                                input logic [31:0] data, input int k);
        int a;
        int p;
        if (clr) begin
            a = ((int'(word) / 16) % 4) * 256 + k;
            p = 0;
        end else begin
            a = int'(word) * 16 + k;
            p = int'((data >> (2 * k)) & 32'd3);
        end
        return {10'(a), 2'(p)};
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("idle_outputs", 32'({we, busy, done, bus.cmd_ready}), 32'b0001);
        end
    endtask

    // Issue at a negedge where the engine should be ready; follow writes and the done cycle.
    task automatic exec_cmd(input bit clr, input logic [5:0] word, input logic [31:0] data,
                            input bit keep_valid, input int abort_at);
        int n;
        logic [11:0] e;
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = clr;
        bus.cmd_word  = word;
        bus.cmd_data  = data;
        check("ready_at_issue", 32'(bus.cmd_ready), 32'd1);
        n = clr ? 256 : 16;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (keep_valid) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_clear = 1'($urandom);
                bus.cmd_word  = 6'($urandom);
                bus.cmd_data  = $urandom;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            e = model_write(clr, word, data, k);
            check($sformatf("write_%s_%0d", clr ? "clr" : "ld", k),
                  32'({we, busy, done, bus.cmd_ready, addr_w, pixel_out}),
                  32'({4'b1100, e}));
            if (k == abort_at) begin
                reset_n = 1'b0;
                #1;
                check("abort_outputs",
                      32'({we, busy, done, bus.cmd_ready, addr_w, pixel_out}), 32'd0);
                return;
            end
        end
        @(negedge clk);
        check("done_cycle", 32'({we, busy, done, bus.cmd_ready}), 32'b0011);
    endtask

    initial begin
        int c0;
        bit clr;
        bit b2b;

        // Reset held with a pending command: nothing may be accepted or written.
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_clear = 1'b0;
        bus.cmd_word  = 6'h25;
        bus.cmd_data  = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("reset_outputs",
                  32'({we, busy, done, bus.cmd_ready, addr_w, pixel_out}), 32'd0);
        end
        reset_n       = 1'b1;
        bus.cmd_valid = 1'b0;
        #1;
        check("ready_after_reset", 32'(bus.cmd_ready), 32'd1);
        idle(2);

        // Directed load: addresses 0x250..0x25F, pixels 0,1,2,3 repeating.
        exec_cmd(1'b0, 6'h25, 32'hE4E4_E4E4, 1'b0, -1);
        idle(2);

        // Directed clear of sid 2, with low word bits and data set to junk.
        exec_cmd(1'b1, 6'b10_1011, 32'hDEAD_BEEF, 1'b0, -1);
        idle(2);

        // Back-to-back loads with valid held high and changing junk during busy.
        c0 = cyc;
        exec_cmd(1'b0, 6'h13, 32'h1B2C_3D4E, 1'b1, -1);
        exec_cmd(1'b0, 6'h3A, 32'h9876_5432, 1'b0, -1);
        check("b2b_cycles", 32'(cyc - c0), 32'd34);
        idle(2);

        // Reset at write 100 of a clear: immediate abandon, no done pulse.
        exec_cmd(1'b1, 6'b01_0000, 32'h0, 1'b0, 100);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_hold", 32'({we, busy, done, bus.cmd_ready}), 32'd0);
        end
        reset_n       = 1'b1;
        bus.cmd_valid = 1'b0;
        #1;
        check("ready_after_abort", 32'(bus.cmd_ready), 32'd1);
        idle(1);
        exec_cmd(1'b0, 6'h07, 32'hA5A5_0F0F, 1'b0, -1);
        idle(1);

        // Randomized mix of loads/clears, gaps and back-to-back issue.
        for (int it = 0; it < 20; it++) begin
            clr = ($urandom_range(3) == 0);
            b2b = 1'($urandom_range(1));
            exec_cmd(clr, 6'($urandom), $urandom, b2b, -1);
            if (!b2b) begin
                bus.cmd_valid = 1'b0;
                idle($urandom_range(3));
            end
        end
        bus.cmd_valid = 1'b0;
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
